// File: rtl/mips_mdu.sv
`default_nettype none
// ============================================================================
// Module      : mips_mdu
// Description : MIPS-style multiply/divide unit with HI/LO registers.
//               Iterative radix-2 datapath: shift-add multiply and restoring
//               shift-subtract divide, one step per clock, WIDTH steps per op.
//               MTHI/MTLO write HI/LO directly in a single cycle.
// Ports       : clk          - clock, all state changes on rising edge
//               reset        - synchronous active-high reset
//               start        - operation request (sampled in IDLE only)
//               op           - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                              100 MTHI, 101 MTLO, 11x reserved
//               operand_a    - rs: multiplicand / dividend / MTHI-MTLO data
//               operand_b    - rt: multiplier / divisor
//               cancel       - flush, aborts any operation in flight
//               busy         - operation in flight
//               done         - one-cycle pulse after HI/LO written by MUL/DIV
//               div_by_zero  - valid with done, divisor was zero
//               hi, lo       - HI and LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_is_div;
    logic                 r_is_signed;
    logic                 r_neg_q;     // quotient / product is negative
    logic                 r_neg_r;     // remainder takes dividend sign
    logic [WIDTH-1:0]     r_a;         // original operand_a, kept for div-by-zero
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_m;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     r_acc;       // product high half / partial remainder
    logic [WIDTH-1:0]     r_q;         // multiplier -> product low / dividend -> quotient
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_b_zero;
    logic                 w_last;

    always_comb begin
        w_a_neg    = r_is_signed & r_a[WIDTH-1];
        w_b_neg    = r_is_signed & r_b[WIDTH-1];
        // Most-negative value maps to 2^(WIDTH-1), which is the correct
        // unsigned magnitude, so no special case is needed here.
        w_a_mag    = w_a_neg ? ({WIDTH{1'b0}} - r_a) : r_a;
        w_b_mag    = w_b_neg ? ({WIDTH{1'b0}} - r_b) : r_b;
        // Multiply step: conditional add, carry kept for the right shift.
        w_sum      = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
        // Divide step: shift next dividend bit into the partial remainder.
        w_shift    = {r_acc, r_q[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_m});
        w_diff     = w_shift[WIDTH-1:0] - r_m;
        w_prod     = {r_acc, r_q};
        w_prod_fix = r_neg_q ? ({(2*WIDTH){1'b0}} - w_prod) : w_prod;
        w_quo      = r_neg_q ? ({WIDTH{1'b0}} - r_q) : r_q;
        w_rem      = r_neg_r ? ({WIDTH{1'b0}} - r_acc) : r_acc;
        w_b_zero   = (r_b == {WIDTH{1'b0}});
        w_last     = (r_count == c_cnt_w'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_m         <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (cancel && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !cancel) begin
                            case (op)
                                3'b000, 3'b001, 3'b010, 3'b011: begin
                                    r_a         <= operand_a;
                                    r_b         <= operand_b;
                                    r_is_div    <= op[1];
                                    r_is_signed <= ~op[0];
                                    r_state     <= S_PREP;
                                end
                                3'b100:  r_hi <= operand_a;
                                3'b101:  r_lo <= operand_a;
                                default: ;
                            endcase
                        end
                    end
                    S_PREP: begin
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_acc   <= '0;
                        r_count <= '0;
                        if (r_is_div) begin
                            r_q <= w_a_mag;
                            r_m <= w_b_mag;
                        end else begin
                            r_q <= w_b_mag;
                            r_m <= w_a_mag;
                        end
                        r_state <= S_ITER;
                    end
                    S_ITER: begin
                        if (r_is_div) begin
                            r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], w_ge};
                        end else begin
                            r_acc <= w_sum[WIDTH:1];
                            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                        end
                        r_count <= r_count + c_cnt_w'(1);
                        if (w_last) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (r_is_div) begin
                            if (w_b_zero) begin
                                r_hi <= r_a;
                                r_lo <= {WIDTH{1'b1}};
                            end else begin
                                r_hi <= w_rem;
                                r_lo <= w_quo;
                            end
                            r_dbz <= w_b_zero;
                        end else begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mdu
// Description : Directed self-checking bench for mips_mdu (WIDTH=32).
//               Inputs change on the falling edge, outputs sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_mdu #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Issue one MUL/DIV from a falling edge and follow it until done (bounded).
    // Returns at the falling edge of the done cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output bit saw_done, output bit dbz_at_done,
                         output int stray_dbz);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; saw_done = 1'b0; dbz_at_done = 1'b0; stray_dbz = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) nbusy++;
            if (done) begin
                saw_done    = 1'b1;
                dbz_at_done = div_by_zero;
                break;
            end
            if (div_by_zero) stray_dbz++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; cancel = 1'b1; op = 3'b100;
        operand_a = 32'hDEAD_BEEF; operand_b = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0; start = 1'b0; cancel = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_mult();
        int nb, st; bit sd, dz;
        do_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, nb, sd, dz, st);
        n_cmp++; if (nb !== 34) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 34", nb); end
        n_cmp++; if (sd !== 1'b1) begin n_fail++; $display("FAIL mult_done: got %b expected 1", sd); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
        n_cmp++; if (dz !== 1'b0) begin n_fail++; $display("FAIL mult_dbz: got %b expected 0", dz); end
        // most-negative squared: 2^62
        do_op(3'b000, 32'h8000_0000, 32'h8000_0000, nb, sd, dz, st);
        n_cmp++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL mult_minneg: got %h expected 4000000000000000", {hi, lo}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int nb, st; bit sd, dz;
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, sd, dz, st);
        n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_prod: got %h expected fffffffe00000001", {hi, lo}); end
        // next start issued in the done cycle
        do_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, nb, sd, dz, st);
        n_cmp++; if (nb !== 34) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 34", nb); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
        do_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, nb, sd, dz, st);
        n_cmp++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_fail++; $display("FAIL div_negb: got %h expected 00000001fffffffd", {hi, lo}); end
        @(negedge clk);
    endtask

    task automatic test_div_special();
        int nb, st; bit sd, dz;
        do_op(3'b011, 32'h0000_0007, 32'h0000_0000, nb, sd, dz, st);
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
        n_cmp++; if (hi !== 32'h0000_0007) begin n_fail++; $display("FAIL dbz_hi: got %h expected 00000007", hi); end
        n_cmp++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", dz); end
        n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL dbz_early: got %0d expected 0", st); end
        @(negedge clk);
        n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_one_cycle: got %b expected 0", div_by_zero); end
        do_op(3'b010, 32'hFFFF_FFF3, 32'h0000_0000, nb, sd, dz, st);
        n_cmp++; if ({hi, lo, dz} !== {32'hFFFF_FFF3, 32'hFFFF_FFFF, 1'b1}) begin n_fail++; $display("FAIL dbz_signed: got %h/%h/%b expected fffffff3/ffffffff/1", hi, lo, dz); end
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, nb, sd, dz, st);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL ovf_hi: got %h expected 00000000", hi); end
        n_cmp++; if (dz !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz: got %b expected 0", dz); end
        @(negedge clk);
    endtask

    task automatic test_mt();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1; op = 3'b100; operand_a = 32'h1234_5678;
        @(negedge clk);
        n_cmp++; if ({hi, lo} !== {32'h1234_5678, 32'h0}) begin n_fail++; $display("FAIL mthi: got %h/%h expected 12345678/00000000", hi, lo); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL mthi_busy: got %b expected 00", {busy, done}); end
        op = 3'b101; operand_a = 32'h9ABC_DEF0;
        @(negedge clk);
        n_cmp++; if ({hi, lo} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin n_fail++; $display("FAIL mtlo: got %h/%h expected 12345678/9abcdef0", hi, lo); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL mtlo_busy: got %b expected 00", {busy, done}); end
        // reserved op codes
        op = 3'b110; operand_a = 32'h5555_5555;
        @(negedge clk);
        op = 3'b111;
        @(negedge clk);
        n_cmp++; if ({busy, hi, lo} !== {1'b0, 32'h1234_5678, 32'h9ABC_DEF0}) begin n_fail++; $display("FAIL reserved_op: got %b/%h/%h expected 0/12345678/9abcdef0", busy, hi, lo); end
        // cancel suppresses start, including MTHI
        op = 3'b100; operand_a = 32'hDEAD_BEEF; cancel = 1'b1;
        @(negedge clk);
        op = 3'b000;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        n_cmp++; if ({busy, hi, lo} !== {1'b0, 32'h1234_5678, 32'h9ABC_DEF0}) begin n_fail++; $display("FAIL cancel_start: got %b/%h/%h expected 0/12345678/9abcdef0", busy, hi, lo); end
    endtask

    task automatic test_cancel();
        int nd = 0;
        start = 1'b1; op = 3'b000; operand_a = 32'h3; operand_b = 32'h5;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);     // now in ITER cycle 10
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_iter_busy: got %b expected 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL cancel_iter_done: got %0d pulses expected 0", nd); end
        n_cmp++; if ({hi, lo} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin n_fail++; $display("FAIL cancel_iter_hilo: got %h/%h expected 12345678/9abcdef0", hi, lo); end
        // cancel in the FIX cycle beats the HI/LO write
        start = 1'b1; op = 3'b000; operand_a = 32'h3; operand_b = 32'h5;
        @(negedge clk);
        start = 1'b0;
        repeat (33) @(negedge clk);     // now in FIX
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL cancel_fix_flags: got %b expected 00", {busy, done}); end
        n_cmp++; if ({hi, lo} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin n_fail++; $display("FAIL cancel_fix_hilo: got %h/%h expected 12345678/9abcdef0", hi, lo); end
    endtask

    task automatic test_start_while_busy();
        int nb = 0; bit sd = 1'b0;
        start = 1'b1; op = 3'b000; operand_a = 32'h3; operand_b = 32'h5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) nb++;
            if (done) begin sd = 1'b1; break; end
            if (i == 5) begin start = 1'b1; op = 3'b100; operand_a = 32'hAAAA_AAAA; end
            if (i == 6) begin op = 3'b001; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; end
            if (i == 7) start = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if ({sd, nb} !== {1'b1, 32'd34}) begin n_fail++; $display("FAIL busy_start_timing: got done=%b busy=%0d expected 1/34", sd, nb); end
        n_cmp++; if ({hi, lo} !== {32'h0, 32'hF}) begin n_fail++; $display("FAIL busy_start_result: got %h/%h expected 00000000/0000000f", hi, lo); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_queued: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_op();
        int nb, st; bit sd, dz;
        start = 1'b1; op = 3'b011; operand_a = 32'd100; operand_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);     // in ITER
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if ({busy, done, div_by_zero, hi, lo} !== 67'h0) begin n_fail++; $display("FAIL reset_mid: got %b%b%b/%h/%h expected all zero", busy, done, div_by_zero, hi, lo); end
        do_op(3'b011, 32'd100, 32'd3, nb, sd, dz, st);
        n_cmp++; if ({sd, nb} !== {1'b1, 32'd34}) begin n_fail++; $display("FAIL after_reset_timing: got done=%b busy=%0d expected 1/34", sd, nb); end
        n_cmp++; if (lo !== 32'h21) begin n_fail++; $display("FAIL after_reset_lo: got %h expected 00000021", lo); end
        n_cmp++; if (hi !== 32'h1) begin n_fail++; $display("FAIL after_reset_hi: got %h expected 00000001", hi); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'b000;
        operand_a = '0; operand_b = '0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_back_to_back();
        test_div_special();
        test_mt();
        test_cancel();
        test_start_while_busy();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_mdu.md
MIPS_MDU -- requirements
Module: mips_mdu

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/HI/LO width in bits (legal range 4..64).
REQ-002 The block SHALL have these ports:
  - clk  input  1  single clock; all state changes on its rising edge.
  - reset  input  1  synchronous, active-high reset.
  - start  input  1  request; sampled on each rising edge.
  - op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
  - operand_a  input  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
  - operand_b  input  WIDTH  rt value: multiplier or divisor.
  - cancel  input  1  pipeline flush; aborts any operation in flight.
  - busy  output  1  high while an operation is in flight.
  - done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
  - div_by_zero  output  1  valid with done; divisor was zero.
  - hi  output  WIDTH  HI register.
  - lo  output  WIDTH  LO register.

Function
REQ-003 The block SHALL implement states IDLE, PREP, ITER and FIX, with busy = (state != IDLE).
REQ-004 In IDLE, with start=1, cancel=0 and op in {000..011}, the block SHALL latch op and operands and move to PREP.
REQ-005 PREP SHALL convert signed operands (MULT/DIV) to magnitudes, record result signs, clear the iteration counter, and move to ITER.
REQ-006 ITER SHALL perform one radix-2 step per cycle, exactly WIDTH cycles: shift-add for multiply, restoring shift-subtract for divide. It SHALL then move to FIX.
REQ-007 FIX SHALL apply sign correction, write HI/LO, register done=1, and return to IDLE.
REQ-008 Latency SHALL be WIDTH+2 rising edges from the start-accepting edge to the edge that writes HI/LO. done SHALL be high in the cycle that follows that edge (WIDTH=32: 34 edges).
REQ-009 Multiply SHALL write {hi,lo} = full 2*WIDTH-bit product: two's complement for MULT, unsigned for MULTU.
REQ-010 Divide SHALL write lo = quotient and hi = remainder. For DIV, the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-011 DIV with operand_a = most-negative and operand_b = -1 SHALL give lo = most-negative and hi = 0 (wrap, no flag).
REQ-012 A divisor of zero (DIV or DIVU) SHALL give lo = all ones, hi = operand_a unmodified, and div_by_zero=1 alongside done.
REQ-013 div_by_zero SHALL be 0 in every cycle where done=0.
REQ-014 MTHI/MTLO in IDLE with start=1 and cancel=0 SHALL write operand_a to hi/lo at that edge. They SHALL take one cycle, never assert busy or done, and leave the other register unchanged.
REQ-015 start while busy=1 SHALL be ignored, with no queuing. Reserved op codes SHALL be ignored.
REQ-016 A new start SHALL be accepted in the same cycle that done is high.
REQ-017 cancel=1 in PREP, ITER or FIX SHALL return the block to IDLE at the next edge, with hi/lo unchanged and no done pulse. cancel in the same edge as FIX takes priority over the HI/LO write.
REQ-018 cancel=1 together with start=1 in IDLE SHALL suppress the start, including MTHI/MTLO.
REQ-019 hi and lo SHALL change only on the FIX write, an MTHI/MTLO write, or reset.

Reset
REQ-020 reset=1 at a rising edge SHALL force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0 and counter=0, overriding start and cancel.
REQ-021 reset asserted mid-operation SHALL discard the operation with no done pulse. The first start after reset deasserts SHALL be accepted normally.

Verification (WIDTH=32)
REQ-022 MULT a=FFFFFFFD (-3), b=00000005 -> busy for 34 cycles, then done=1, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-023 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then DIV a=FFFFFFF9 (-7), b=2 issued in the done cycle -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-024 DIVU a=7, b=0 -> lo=FFFFFFFF, hi=00000007, div_by_zero=1 for exactly one cycle. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_by_zero=0.
REQ-025 Starting from hi=lo=0, the bench SHALL run all of the following and check each response:
  - MTHI 12345678, then MTLO 9ABCDEF0 -> hi=12345678, lo=9ABCDEF0 after two cycles; busy never set.
  - MULT then cancel at ITER cycle 10 -> busy=0 on the next cycle, hi/lo unchanged, no done.
  - A second start while busy -> ignored.
REQ-026 reset asserted during ITER of DIVU 100/3 -> all outputs 0 at the next edge, no done. A following DIVU 100/3 -> lo=00000021, hi=00000001.
